// File: rtl/touch_gesture_decoder.sv
// Classifies debounced touch presses as TAP, DOUBLE_TAP or LONG_PRESS using a
// prescaled tick timer, and hands each gesture out through a one-entry event register.
//
// state  | meaning
// IDLE   | no finger, waiting for a press
// PRESS1 | first press in progress, timing toward long press
// WAIT2  | released after a short press, waiting for a second press
// PRESS2 | second press in progress, double tap on release
// LONG   | long press already reported, waiting for release
module touch_gesture_decoder #(
    parameter int TICK_DIV       = 12000,
    parameter int LONG_TICKS     = 500,
    parameter int DTAP_GAP_TICKS = 250
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       btn,
    output logic       evt_valid,
    output logic [1:0] evt_code,
    input  logic       evt_ready,
    output logic       held,
    output logic       evt_overrun
);

    localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [1:0] CODE_TAP  = 2'b01;
    localparam logic [1:0] CODE_DTAP = 2'b10;
    localparam logic [1:0] CODE_LONG = 2'b11;

    typedef enum logic [2:0] {
        S_IDLE,
        S_PRESS1,
        S_WAIT2,
        S_PRESS2,
        S_LONG
    } state_t;

    state_t          state, state_n;
    logic [PW-1:0]   presc;
    logic [9:0]      dur;
    logic            btn_q;
    logic            tick, rise, fall;
    logic            expire_long, expire_gap;
    logic            new_evt;
    logic [1:0]      new_code;
    logic            accept;

    assign tick        = (presc == PW'(TICK_DIV - 1));
    assign rise        = btn & ~btn_q;
    assign fall        = ~btn & btn_q;
    assign expire_long = tick && (dur == 10'(LONG_TICKS - 1));
    assign expire_gap  = tick && (dur == 10'(DTAP_GAP_TICKS - 1));
    assign accept      = evt_valid & evt_ready;

    always_comb begin
        state_n  = state;
        new_evt  = 1'b0;
        new_code = 2'b00;
        case (state)
            S_IDLE: begin
                if (rise) state_n = S_PRESS1;
            end
            // Edges are checked before expiry so a coincident edge suppresses the event.
            S_PRESS1: begin
                if (fall) begin
                    state_n = S_WAIT2;
                end else if (expire_long) begin
                    state_n  = S_LONG;
                    new_evt  = 1'b1;
                    new_code = CODE_LONG;
                end
            end
            S_WAIT2: begin
                if (rise) begin
                    state_n = S_PRESS2;
                end else if (expire_gap) begin
                    state_n  = S_IDLE;
                    new_evt  = 1'b1;
                    new_code = CODE_TAP;
                end
            end
            S_PRESS2: begin
                if (fall) begin
                    state_n  = S_IDLE;
                    new_evt  = 1'b1;
                    new_code = CODE_DTAP;
                end
            end
            S_LONG: begin
                if (fall) state_n = S_IDLE;
            end
            default: state_n = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= S_IDLE;
            presc <= '0;
            dur   <= '0;
            btn_q <= 1'b1;
            held  <= 1'b0;
        end else begin
            state <= state_n;
            btn_q <= btn;
            held  <= (state_n == S_LONG);
            presc <= tick ? '0 : presc + PW'(1);
            if (state_n != state) begin
                dur <= '0;
            end else if (tick && (dur != 10'h3FF)) begin
                dur <= dur + 10'd1;
            end
        end
    end

    // A new event never displaces an unread one; the loss is flagged instead.
    always_ff @(posedge clk) begin
        if (reset) begin
            evt_valid   <= 1'b0;
            evt_code    <= 2'b00;
            evt_overrun <= 1'b0;
        end else if (new_evt) begin
            if (!evt_valid || accept) begin
                evt_valid <= 1'b1;
                evt_code  <= new_code;
            end else begin
                evt_overrun <= 1'b1;
            end
        end else if (accept) begin
            evt_valid <= 1'b0;
            evt_code  <= 2'b00;
        end
    end

endmodule

// File: tb/tb_touch_gesture_decoder.sv
// Randomised and directed bench for touch_gesture_decoder; a gesture-level
// reference model feeds a scoreboard that a separate monitor drains.
module tb_touch_gesture_decoder;

    localparam int TICK_DIV = 4;
    localparam int LONG_T   = 8;
    localparam int GAP_T    = 4;

    logic       clk = 1'b0;
    logic       reset;
    logic       btn;
    logic       evt_valid;
    logic [1:0] evt_code;
    logic       evt_ready;
    logic       held;
    logic       evt_overrun;

    touch_gesture_decoder #(
        .TICK_DIV(TICK_DIV), .LONG_TICKS(LONG_T), .DTAP_GAP_TICKS(GAP_T)
    ) dut (
        .clk(clk), .reset(reset), .btn(btn),
        .evt_valid(evt_valid), .evt_code(evt_code), .evt_ready(evt_ready),
        .held(held), .evt_overrun(evt_overrun)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int tcyc   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, tcyc);
        end
    endtask

    // Reference model: gesture phases timed by counting ticks arithmetically
    // from the cycle a phase was entered.
    typedef enum {G_IDLE, G_PRESS1, G_WAIT2, G_PRESS2, G_LONG} gphase_t;
    gphase_t    ph = G_IDLE;
    gphase_t    nph;
    int         cyc = 0;
    int         entry = 0;
    bit         armed = 0;
    bit         bprev = 1;
    bit         mv = 0;
    bit         movr = 0;
    bit         mheld = 0;
    bit         m_rise, m_fall, m_acc;
    logic [1:0] newc;
    logic [1:0] exp_q[$];
    logic [1:0] ec;

    function automatic int ticks_through(input int c);
        return (c + 1) / TICK_DIV;
    endfunction

    function automatic bit expires(input int c, input int n);
        return ((c % TICK_DIV) == TICK_DIV - 1) &&
               ((ticks_through(c) - ticks_through(entry)) == n);
    endfunction

    always @(posedge clk) begin
        tcyc++;
        if (reset) begin
            armed = 1;
            ph    = G_IDLE;
            bprev = 1;
            cyc   = 0;
            entry = 0;
            mv    = 0;
            movr  = 0;
            mheld = 0;
            exp_q.delete();
        end else if (armed) begin
            m_rise = btn && !bprev;
            m_fall = !btn && bprev;
            newc   = 2'b00;
            nph    = ph;
            case (ph)
                G_IDLE:   if (m_rise) nph = G_PRESS1;
                G_PRESS1: if (m_fall) nph = G_WAIT2;
                          else if (expires(cyc, LONG_T)) begin nph = G_LONG; newc = 2'b11; end
                G_WAIT2:  if (m_rise) nph = G_PRESS2;
                          else if (expires(cyc, GAP_T)) begin nph = G_IDLE; newc = 2'b01; end
                G_PRESS2: if (m_fall) begin nph = G_IDLE; newc = 2'b10; end
                G_LONG:   if (m_fall) nph = G_IDLE;
                default:  nph = G_IDLE;
            endcase
            if (nph != ph) entry = cyc;
            ph    = nph;
            bprev = btn;
            mheld = (ph == G_LONG);
            m_acc = mv && evt_ready;
            if (newc != 2'b00) begin
                if (!mv || m_acc) begin
                    exp_q.push_back(newc);
                    mv = 1;
                end else begin
                    movr = 1;
                end
            end else if (m_acc) begin
                mv = 0;
            end
            cyc++;
        end
    end

    always @(negedge clk) begin
        if (armed) begin
            ec = (mv && exp_q.size() > 0) ? exp_q[0] : 2'b00;
            chk("evt_valid", 32'(evt_valid), 32'(mv));
            chk("evt_code", 32'(evt_code), 32'(ec));
            chk("held", 32'(held), 32'(mheld));
            chk("evt_overrun", 32'(evt_overrun), 32'(movr));
            if (evt_valid && evt_ready) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_event: got code %0d, expected no event (cycle %0d)", evt_code, tcyc);
                end else begin
                    chk("accepted_code", 32'(evt_code), 32'(exp_q[0]));
                    void'(exp_q.pop_front());
                end
            end
        end
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Drive btn to lvl on exactly the cycle in which the phase expiry would fire.
    task automatic hit_expiry(input gphase_t p, input int n, input bit lvl, input string name);
        int  k;
        bit  hit;
        k   = 0;
        hit = 0;
        while (k < 200 && !hit) begin
            if (ph == p && expires(cyc, n)) hit = 1;
            else begin step(1); k++; end
        end
        chk(name, 32'(hit), 32'd1);
        btn = lvl;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset     = 1'b1;
        btn       = 1'b0;
        evt_ready = 1'b1;
        step(3);
        reset = 1'b0;
        step(2);

        // Single tap
        btn = 1'b1; step(10); btn = 1'b0; step(40);
        // Double tap
        btn = 1'b1; step(8); btn = 1'b0; step(6);
        btn = 1'b1; step(8); btn = 1'b0; step(20);
        // Long press
        btn = 1'b1; step(50);
        chk("t3_held", 32'(held), 32'd1);
        step(10); btn = 1'b0; step(3);
        chk("t3_held_after_release", 32'(held), 32'd0);
        step(10);
        // Back-pressure: TAP then DOUBLE_TAP while not ready
        evt_ready = 1'b0;
        btn = 1'b1; step(8); btn = 1'b0; step(30);
        btn = 1'b1; step(8); btn = 1'b0; step(6);
        btn = 1'b1; step(8); btn = 1'b0; step(10);
        chk("t4_code_kept", 32'(evt_code), 32'd1);
        chk("t4_overrun", 32'(evt_overrun), 32'd1);
        evt_ready = 1'b1; step(2);
        chk("t4_drained", 32'(evt_valid), 32'd0);
        step(5);
        // Reset mid-press with finger held
        btn = 1'b1; step(5);
        reset = 1'b1; step(1); reset = 1'b0;
        chk("t5_valid", 32'(evt_valid), 32'd0);
        chk("t5_code", 32'(evt_code), 32'd0);
        chk("t5_held", 32'(held), 32'd0);
        chk("t5_overrun", 32'(evt_overrun), 32'd0);
        step(40); btn = 1'b0; step(30);
        // Second press lands on the gap-expiry cycle
        btn = 1'b1; step(6); btn = 1'b0; step(2);
        hit_expiry(G_WAIT2, GAP_T, 1'b1, "t6_gap_edge_reached");
        step(6); btn = 1'b0; step(20);
        // Release lands on the long-press expiry cycle
        btn = 1'b1; step(2);
        hit_expiry(G_PRESS1, LONG_T, 1'b0, "t6_long_edge_reached");
        step(40);

        for (int i = 0; i < 300; i++) begin
            if ($urandom_range(0, 59) == 0) begin
                reset = 1'b1; step(1); reset = 1'b0;
            end
            evt_ready = ($urandom_range(0, 3) != 0);
            btn = ~btn;
            if (btn) step($urandom_range(1, 45));
            else     step($urandom_range(1, 25));
        end

        btn = 1'b0; evt_ready = 1'b1; step(60);
        chk("final_drain", 32'(evt_valid), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
